// File: rtl/ram_rw_seq_ctrl.sv
// RAM self-test sequencer: fills a simple dual-port RAM with an (addr + seed) pattern,
// reads it back through the read port and tallies mismatches; optional looping with a rolling seed.
module ram_rw_seq_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 256,
    parameter int RD_LAT  = 1,
    parameter int GAP_CYC = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              loop_en,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       pass_cnt,
    output logic              err_flag,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int CW_D  = $clog2(DEPTH + 1);
    localparam int CW_G  = $clog2(GAP_CYC + 1);
    localparam int CNT_W = (CW_D > CW_G) ? CW_D : CW_G;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE, S_GAP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic                wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [15:0]         pass_cnt_q, pass_cnt_d, err_cnt_q, err_cnt_d;
    logic                err_flag_q, err_flag_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

    logic                pipe_v_q    [RD_LAT];
    logic [DATA_W-1:0]   pipe_exp_q  [RD_LAT];
    logic [ADDR_W-1:0]   pipe_addr_q [RD_LAT];

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] s);
        return DATA_W'(a) + s;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seed_d     = seed_q;
        pass_cnt_d = pass_cnt_q;
        err_flag_d = err_flag_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;

        unique case (state_q)
            S_IDLE: if (start) begin
                state_d    = S_WRITE;
                cnt_d      = '0;
                err_flag_d = 1'b0;
                err_cnt_d  = '0;
                err_addr_d = '0;
            end
            S_WRITE: if (cnt_q == CNT_W'(DEPTH - 1)) begin
                state_d = S_READ;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_READ: if (cnt_q == CNT_W'(DEPTH - 1)) begin
                state_d = S_DRAIN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_DRAIN: if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                state_d    = S_DONE;
                cnt_d      = '0;
                pass_cnt_d = pass_cnt_q + 16'd1;
                seed_d     = seed_q + DATA_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_DONE: begin
                state_d = loop_en ? S_GAP : S_IDLE;
                cnt_d   = '0;
            end
            S_GAP: if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                state_d = loop_en ? S_WRITE : S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // Pipeline tail lines up with the cycle the RAM presents the matching read word.
        if ((state_q == S_READ || state_q == S_DRAIN) && pipe_v_q[RD_LAT-1] &&
            (ram_rd_data != pipe_exp_q[RD_LAT-1])) begin
            err_flag_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
            if (!err_flag_q) err_addr_d = pipe_addr_q[RD_LAT-1];
        end

        wr_en_d   = (state_d == S_WRITE);
        wr_addr_d = wr_en_d ? ADDR_W'(cnt_d) : wr_addr_q;
        wr_data_d = wr_en_d ? pat(ADDR_W'(cnt_d), seed_d) : wr_data_q;
        rd_en_d   = (state_d == S_READ);
        rd_addr_d = rd_en_d ? ADDR_W'(cnt_d) : rd_addr_q;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            seed_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_cnt_q <= '0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            for (int unsigned i = 0; i < unsigned'(RD_LAT); i++) begin
                pipe_v_q[i]    <= 1'b0;
                pipe_exp_q[i]  <= '0;
                pipe_addr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seed_q     <= seed_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_cnt_q <= pass_cnt_d;
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
            pipe_v_q[0]    <= rd_en_q;
            pipe_exp_q[0]  <= pat(rd_addr_q, seed_q);
            pipe_addr_q[0] <= rd_addr_q;
            for (int unsigned i = 1; i < unsigned'(RD_LAT); i++) begin
                pipe_v_q[i]    <= pipe_v_q[i-1];
                pipe_exp_q[i]  <= pipe_exp_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
            end
        end
    end

    assign ram_wr_en   = wr_en_q;
    assign ram_wr_addr = wr_addr_q;
    assign ram_wr_data = wr_data_q;
    assign ram_rd_en   = rd_en_q;
    assign ram_rd_addr = rd_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass_cnt    = pass_cnt_q;
    assign err_flag    = err_flag_q;
    assign err_cnt     = err_cnt_q;
    assign err_addr    = err_addr_q;

endmodule

// File: doc/ram_rw_seq_ctrl.md
Name: ram_rw_seq_ctrl

Overview:
- Sequencer for the simple dual-port RAM (port A write-only, port B read-only, single clock) in the ip_2port_ram design.
- On a start pulse it fills the RAM with a deterministic pattern through port A, then reads it back through port B and checks every word.
- Reports pass count, error flag/count and first failing address.
- Optional loop mode repeats passes with a rolling pattern seed. Used as the on-chip RAM self-test and traffic generator.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 256, words exercised per pass; 2 <= DEPTH <= 2^ADDR_W.
- RD_LAT, 1, RAM port-B read latency in cycles; legal values 1 or 2.
- GAP_CYC, 4, idle cycles between passes in loop mode; must be >= 1.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle start pulse, honoured only in IDLE
- loop_en  in  1  level; 1 = run passes back-to-back
- ram_wr_en  out  1  port-A write enable
- ram_wr_addr  out  ADDR_W  port-A address
- ram_wr_data  out  DATA_W  port-A write data
- ram_rd_en  out  1  port-B read enable
- ram_rd_addr  out  ADDR_W  port-B address
- ram_rd_data  in  DATA_W  port-B read data, valid RD_LAT cycles after the rd_en cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of each pass
- pass_cnt  out  16  completed passes, wraps at 65535->0
- err_flag  out  1  sticky mismatch flag
- err_cnt  out  16  mismatch count, saturates at 65535
- err_addr  out  ADDR_W  address of first mismatch since last start

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; seed 0; compare pipeline cleared. Reset mid-pass aborts immediately. After release there is no RAM activity until a new start.
- All outputs are registered.
- States: IDLE, WRITE, READ, DRAIN, DONE, GAP.
- IDLE: start=1 at edge N -> WRITE from N+1. Same edge clears err_flag, err_cnt and err_addr. pass_cnt and seed are not cleared.
- WRITE: ram_wr_en=1 for exactly DEPTH consecutive cycles; addr 0..DEPTH-1.
  - ram_wr_data = (addr + seed) mod 2^DATA_W. Addr is zero-extended or truncated to DATA_W before the add.
  - After addr DEPTH-1 -> READ.
- READ: ram_rd_en=1 for exactly DEPTH consecutive cycles; addr 0..DEPTH-1. The first read immediately follows the last write cycle, so there is no read-before-write on the same address.
  - Expected data and a valid bit are pushed into an RD_LAT-deep shift pipeline.
- DRAIN: RD_LAT cycles with rd_en=0, letting the final read words reach the comparator -> DONE.
- Compare: whenever the pipeline output valid=1 and ram_rd_data != expected, the block sets err_flag and increments err_cnt (saturating).
  - err_addr is loaded only if err_flag was 0 before this mismatch.
  - Comparison is active in READ and DRAIN only.
- DONE: done=1 for one cycle; pass_cnt+1; seed+1 (mod 2^DATA_W).
  - If loop_en=1 (sampled in DONE) -> GAP, else -> IDLE.
- GAP: GAP_CYC cycles with no RAM activity -> WRITE.
  - If loop_en drops during GAP, the block returns to IDLE after the gap expires.
  - Clearing loop_en during WRITE/READ/DRAIN finishes the current pass, then IDLE.
- start outside IDLE is ignored and has no side effect.
- wr_en and rd_en are never high in the same cycle.
- Outside WRITE, wr_addr/wr_data hold their last value; outside READ, rd_addr holds its last value.
- Pass length is 2*DEPTH + RD_LAT + 1 cycles, start edge to done pulse inclusive of DONE.
- busy=1 from the cycle after start through DONE and GAP.

Test Plan:
1. Reset (DEPTH=16, DATA_W=8, RD_LAT=1, behavioural RAM) -> all outputs 0, busy=0; no wr_en/rd_en for 50 cycles without start.
2. Single pass, loop_en=0:
   - Required: wr_en for 16 cycles with addr/data 0..15, then rd_en for 16 cycles with addr 0..15.
   - Required: done pulse 34 cycles after the start edge; pass_cnt=1, err_flag=0, err_cnt=0, busy=0 afterwards.
3. Error injection: RAM model returns data^8'h01 at addr 5 and addr 9 -> err_flag=1, err_cnt=2, err_addr=5. A new start clears all three.
4. Loop with DATA_W=4, DEPTH=16, loop_en=1, 3 passes:
   - Pass 2 writes data 1..15,0; pass 3 writes data 2..15,0,1.
   - Exactly GAP_CYC=4 idle cycles between each done and the next wr_en.
   - Drop loop_en in pass 3 -> IDLE after its done; pass_cnt=3.
5. Reset asserted mid-WRITE at addr 7 -> outputs 0 within the same cycle (async). After release, IDLE with no RAM activity. The next start runs a full clean pass with seed=0.
6. RD_LAT=2, start pulsed during READ -> start ignored; DRAIN lasts 2 cycles; all 16 words are compared (err_cnt=0); pass length is 35 cycles.
